pixel_stream_tx: RTL and testbench
==================================

// Module: pixel_stream_tx
// PURPOSE
//  Raster transmitter: converts an AXI-stream of 24-bit pixels into the camera-style
//  parallel pixel bus (pdata/pvld/hsync/vsync) that img_buf consumes.
//  It is the source end of that bus: a bench/loopback driver and the path to a display.
//  It generates frame timing from counters and pulls pixels from axis_i only in active slots.
// PARAMETERS
//  H_ACTIVE  10  active pixels per line (>=1)
//  H_BLANK    3  blank cycles after each line's active region (>=1)
//  V_ACTIVE  50  active lines per frame (>=1)
//  V_BLANK    2  blank line periods after the frame; each is H_ACTIVE+H_BLANK cycles (>=1)
// PORTS
//  clk        in   1   single clock, all logic posedge
//  rst_n      in   1   asynchronous active-low reset
//  en         in   1   frame enable, sampled only in IDLE
//  axis_i     in   if  axis_if #(.DATA_TYPE(logic [23:0])) sink: data, vld in; rdy out
//  pdata      out  24  pixel data, valid when pvld
//  pvld       out  1   pixel valid
//  hsync      out  1   high during a line's active region
//  vsync      out  1   high from first active pixel of line 0 to last cycle of line V_ACTIVE-1
//  frame_done out  1   1-cycle pulse on the last cycle of the final V_BLANK line
//  underflow  out  1   sticky: an active slot found axis_i.vld=0
// BEHAVIOUR
//  - Reset (async assert, sync release): pdata=0, pvld=0, hsync=0, vsync=0,
//    frame_done=0, underflow=0, axis_i.rdy=0, counters x=y=0, state IDLE.
//  - FSM: IDLE -> ACTIVE when en=1 (underflow cleared on this transition).
//    ACTIVE (x<H_ACTIVE) -> HBLANK after x==H_ACTIVE-1.
//    HBLANK -> ACTIVE (y+1) after H_BLANK cycles if y<V_ACTIVE-1, else -> VBLANK.
//    VBLANK lasts V_BLANK*(H_ACTIVE+H_BLANK) cycles, then pulses frame_done and goes to:
//    ACTIVE (new frame, y=0) if en=1, else IDLE.
//  - en=0 mid-frame has no effect until the frame completes.
//  - axis_i.rdy is combinational: rdy = (state==ACTIVE). Handshake = vld&&rdy.
//  - Outputs are registered; latency is 1 cycle. A slot at cycle t appears on pdata/pvld at t+1.
//  - hsync and vsync are aligned with pvld: the same registered stage.
//  - Active slot with handshake: pvld=1, pdata=axis_i.data.
//  - Active slot without vld: pvld=0, pdata=0, underflow<=1. Timing never stalls and the pixel is skipped.
//  - Blank cycles: pvld=0, pdata=0, no data is consumed (rdy=0).
//  - Per frame: exactly H_ACTIVE*V_ACTIVE slots.
//  - Frame period: (V_ACTIVE+V_BLANK)*(H_ACTIVE+H_BLANK) cycles.
//  - x/y counter widths: $clog2 of their maxima. Counters wrap to 0 at line and frame ends.
//  - Reset mid-line: all outputs drop to reset values immediately. The next frame restarts at x=y=0.
// TESTING
//  1. H_ACTIVE=4,H_BLANK=3,V_ACTIVE=2,V_BLANK=1; always-valid data 0..7, en=1 ->
//     pvld pattern 1111000 1111000 0000000 per frame.
//     pdata = 0,1,2,3 then 4,5,6,7; hsync mirrors pvld.
//     vsync high for 14 cycles; frame_done at cycle 21; frame repeats with data 8...
//  2. Defaults, vld toggling 1/0 each cycle ->
//     only handshaken beats appear, in order; underflow=1 after first miss.
//     hsync still 10 high / 3 low for 50 lines.
//  3. en=1 for one cycle only -> exactly one frame emitted, frame_done pulses once,
//     then IDLE with rdy=0 and all outputs 0.
//  4. en deasserted at line 1 of frame -> frame completes all V_ACTIVE lines + VBLANK,
//     then IDLE.
//  5. rst_n low during x=2 of line 5 -> same cycle: outputs 0, rdy=0.
//     After release with en=1 -> fresh frame from x=y=0, underflow=0.
//  6. Loopback: connect pixel_stream_tx to img_buf; count beats on img_buf axis_o ->
//     H_ACTIVE*V_ACTIVE pixels per frame, data order preserved.

Source files
------------

// File: rtl/axis_if.sv
// axis_if: valid/ready stream bundle carrying one DATA_TYPE beat per handshake
interface axis_if #(parameter type DATA_TYPE = logic [23:0]);
    DATA_TYPE data;
    logic     vld;
    logic     rdy;
    modport master (output data, output vld, input rdy);
    modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: raster timing generator that turns an AXI-stream into a parallel pixel bus
module pixel_stream_tx #(
    parameter int H_ACTIVE = 10,
    parameter int H_BLANK  = 3,
    parameter int V_ACTIVE = 50,
    parameter int V_BLANK  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    axis_if.slave       axis_i,
    output logic [23:0] pdata,
    output logic        pvld,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_done,
    output logic        underflow
);
    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int Y_MAX   = (V_ACTIVE > V_BLANK) ? V_ACTIVE : V_BLANK;
    localparam int XW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int YW      = (Y_MAX > 1) ? $clog2(Y_MAX) : 1;
    localparam logic [XW-1:0] X_ACT_LAST = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] X_LINE_END = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT_LAST = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] Y_BLK_LAST = YW'(V_BLANK - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t         state;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           line_end;

    assign line_end   = (x == X_LINE_END);
    assign axis_i.rdy = (state == ACTIVE);

    // x runs across a whole line (active + blank); y counts active lines, then blank lines in VBLANK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            pdata      <= '0;
            pvld       <= 1'b0;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            pdata      <= '0;
            pvld       <= 1'b0;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state     <= ACTIVE;
                        x         <= '0;
                        y         <= '0;
                        underflow <= 1'b0;
                    end
                end
                ACTIVE: begin
                    pvld  <= axis_i.vld;
                    pdata <= axis_i.vld ? axis_i.data : '0;
                    hsync <= 1'b1;
                    vsync <= 1'b1;
                    if (!axis_i.vld) underflow <= 1'b1;
                    x <= x + 1'b1;
                    if (x == X_ACT_LAST) state <= HBLANK;
                end
                HBLANK: begin
                    vsync <= 1'b1;
                    x     <= line_end ? '0 : x + 1'b1;
                    if (line_end) begin
                        if (y == Y_ACT_LAST) begin
                            y     <= '0;
                            state <= VBLANK;
                        end else begin
                            y     <= y + 1'b1;
                            state <= ACTIVE;
                        end
                    end
                end
                VBLANK: begin
                    x <= line_end ? '0 : x + 1'b1;
                    if (line_end) begin
                        if (y == Y_BLK_LAST) begin
                            y          <= '0;
                            frame_done <= 1'b1;
                            state      <= en ? ACTIVE : IDLE;
                        end else begin
                            y <= y + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx: directed checks of raster timing, handshake, underflow and reset behaviour
module tb_pixel_stream_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic s_en = 1'b0;
    logic d_en = 1'b0;
    logic [23:0] s_pdata, d_pdata;
    logic s_pvld, s_hsync, s_vsync, s_done, s_uf;
    logic d_pvld, d_hsync, d_vsync, d_done, d_uf;
    int n_cmp = 0;
    int n_err = 0;
    bit tog = 1'b0;

    axis_if #(.DATA_TYPE(logic [23:0])) s_if();
    axis_if #(.DATA_TYPE(logic [23:0])) d_if();

    pixel_stream_tx #(.H_ACTIVE(4), .H_BLANK(3), .V_ACTIVE(2), .V_BLANK(1)) s_dut (
        .clk(clk), .rst_n(rst_n), .en(s_en), .axis_i(s_if),
        .pdata(s_pdata), .pvld(s_pvld), .hsync(s_hsync), .vsync(s_vsync),
        .frame_done(s_done), .underflow(s_uf)
    );

    pixel_stream_tx d_dut (
        .clk(clk), .rst_n(rst_n), .en(d_en), .axis_i(d_if),
        .pdata(d_pdata), .pvld(d_pvld), .hsync(d_hsync), .vsync(d_vsync),
        .frame_done(d_done), .underflow(d_uf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock; sources advance their data only after an accepted beat
    task automatic step();
        bit hs_s, hs_d;
        hs_s = s_if.vld && s_if.rdy;
        hs_d = d_if.vld && d_if.rdy;
        @(posedge clk);
        #1;
        if (hs_s) s_if.data = s_if.data + 24'd1;
        if (hs_d) d_if.data = d_if.data + 24'd1;
        if (tog) d_if.vld = !d_if.vld;
    endtask

    // Small raster 4+3 by 2+1: 21-cycle frame, pixels base..base+7
    task automatic frame_s(input int base, input bit drop_en);
        for (int c = 0; c < 21; c++) begin
            int l, p;
            bit act;
            l = c / 7;
            p = c % 7;
            act = (l < 2) && (p < 4);
            chk("s_rdy", s_if.rdy, act);
            step();
            if (drop_en && c == 7) s_en = 1'b0;
            chk("s_pvld", s_pvld, act);
            chk("s_pdata", s_pdata, act ? base + l * 4 + p : 0);
            chk("s_hsync", s_hsync, act);
            chk("s_vsync", s_vsync, c < 14);
            chk("s_done", s_done, c == 20);
            chk("s_uf", s_uf, 0);
        end
    endtask

    task automatic idle_s(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("s_idle_rdy", s_if.rdy, 0);
            chk("s_idle_pvld", s_pvld, 0);
            chk("s_idle_pdata", s_pdata, 0);
            chk("s_idle_vsync", s_vsync, 0);
            chk("s_idle_done", s_done, 0);
        end
    endtask

    // Default raster 10+3 by 50+2 with vld alternating; en dropped after the first slot
    task automatic frame_d();
        int exp_d;
        bit uf;
        exp_d = d_if.data;
        uf = 1'b0;
        for (int c = 0; c < 676; c++) begin
            int l, p;
            bit act, v, hit;
            l = c / 13;
            p = c % 13;
            act = (l < 50) && (p < 10);
            v = d_if.vld;
            chk("d_rdy", d_if.rdy, act);
            step();
            if (c == 0) d_en = 1'b0;
            hit = act && v;
            uf = uf | (act && !v);
            chk("d_pvld", d_pvld, hit);
            chk("d_pdata", d_pdata, hit ? exp_d : 0);
            if (hit) exp_d++;
            chk("d_hsync", d_hsync, act);
            chk("d_vsync", d_vsync, l < 50);
            chk("d_done", d_done, c == 675);
            chk("d_uf", d_uf, uf);
        end
    endtask

    initial begin
        int base;
        s_if.vld = 1'b0; s_if.data = '0;
        d_if.vld = 1'b0; d_if.data = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_s_pvld", s_pvld, 0);
        chk("rst_s_pdata", s_pdata, 0);
        chk("rst_s_sync", {s_hsync, s_vsync, s_done, s_uf}, 0);
        chk("rst_s_rdy", s_if.rdy, 0);
        chk("rst_d_out", {d_pvld, d_hsync, d_vsync, d_done, d_uf}, 0);
        chk("rst_d_rdy", d_if.rdy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        s_en = 1'b1;
        s_if.vld = 1'b1;
        step();
        frame_s(0, 1'b0);
        frame_s(8, 1'b1);
        idle_s(3);
        s_en = 1'b1;
        step();
        s_en = 1'b0;
        frame_s(16, 1'b0);
        idle_s(4);
        d_if.vld = 1'b1;
        d_en = 1'b1;
        step();
        tog = 1'b1;
        frame_d();
        tog = 1'b0;
        d_if.vld = 1'b1;
        step();
        chk("d_idle_rdy", d_if.rdy, 0);
        chk("d_idle_pvld", d_pvld, 0);
        d_en = 1'b1;
        step();
        for (int c = 0; c < 67; c++) step();
        chk("d_pre_rst_pvld", d_pvld, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("d_mid_rst_pvld", d_pvld, 0);
        chk("d_mid_rst_pdata", d_pdata, 0);
        chk("d_mid_rst_sync", {d_hsync, d_vsync}, 0);
        chk("d_mid_rst_rdy", d_if.rdy, 0);
        chk("d_mid_rst_uf", d_uf, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        base = d_if.data;
        step();
        chk("d_restart_rdy", d_if.rdy, 1);
        chk("d_restart_uf", d_uf, 0);
        step();
        chk("d_restart_pvld", d_pvld, 1);
        chk("d_restart_pdata", d_pdata, base);
        chk("d_restart_sync", {d_hsync, d_vsync}, 2'b11);
        d_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
